dispensador_billetes: RTL

- Sequences the cash-dispensing mechanism downstream of the ATM controller.
- On ENTREGAR_DINERO it captures MONTO and runs a dry-run greedy decomposition against the bill inventory. If the amount is exactly payable, it issues one bill request per note to the mechanism through a REQ/ACK handshake.
- Keeps per-denomination inventory counters and accepts reloads while idle.

---
 rtl/dispensador_pkg.sv | 26 ++
 rtl/selector_billete.sv | 27 ++
 rtl/dispensador_billetes.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dispensador_pkg.sv
// Shared types and constants for the bill dispenser: FSM states, bill type codes
// and default denominations.
package dispensador_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        VERIFICA   = 2'd1,
        ENTREGA    = 2'd2,
        ESPERA_ACK = 2'd3
    } estado_t;

    typedef logic [1:0] tipo_t;

    localparam tipo_t TIPO_0 = 2'd0;
    localparam tipo_t TIPO_1 = 2'd1;
    localparam tipo_t TIPO_2 = 2'd2;
    localparam tipo_t TIPO_3 = 2'd3;

    localparam int N_TIPOS = 4;

    localparam int unsigned DEN0_DEF = 50;
    localparam int unsigned DEN1_DEF = 20;
    localparam int unsigned DEN2_DEF = 10;
    localparam int unsigned DEN3_DEF = 5;

endpackage

// File: rtl/selector_billete.sv
// Greedy bill picker: lowest type index whose denomination fits the remaining
// amount and whose count is non-zero.
module selector_billete
    import dispensador_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic [31:0]                    rem,
    input  logic [N_TIPOS-1:0][CNT_W-1:0]  cnt,
    input  logic [N_TIPOS-1:0][31:0]       den,
    output logic                           valido,
    output tipo_t                          tipo
);

    // Scanning from the smallest bill upwards lets the largest fitting bill win.
    always_comb begin
        valido = 1'b0;
        tipo   = TIPO_0;
        for (int i = N_TIPOS - 1; i >= 0; i--) begin
            if ((rem >= den[i]) && (cnt[i] != '0)) begin
                valido = 1'b1;
                tipo   = tipo_t'(i);
            end
        end
    end

endmodule

// File: rtl/dispensador_billetes.sv
// Bill dispenser sequencer: dry-run greedy check, then one REQ/ACK handshake per bill.
// Optional ACK timeout is enabled by defining DISP_TIMEOUT_EN.
module dispensador_billetes
    import dispensador_pkg::*;
#(
    parameter int unsigned DEN0           = DEN0_DEF,
    parameter int unsigned DEN1           = DEN1_DEF,
    parameter int unsigned DEN2           = DEN2_DEF,
    parameter int unsigned DEN3           = DEN3_DEF,
    parameter int          CNT_W          = 8,
    parameter int unsigned TIMEOUT_CICLOS = 1000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ENTREGAR_DINERO,
    input  logic [31:0]          MONTO,
    input  logic                 RECARGA_STB,
    input  logic [1:0]           RECARGA_TIPO,
    input  logic [CNT_W-1:0]     RECARGA_CANT,
    input  logic                 BILLETE_ACK,
    output logic                 BILLETE_REQ,
    output logic [1:0]           BILLETE_TIPO,
    output logic                 OCUPADO,
    output logic                 ENTREGA_COMPLETA,
    output logic                 MONTO_INVALIDO,
    output logic                 FALLA_MECANISMO,
    output logic [4*CNT_W-1:0]   INVENTARIO
);

    localparam logic [CNT_W-1:0] UNO = CNT_W'(1);

    estado_t                        state_reg, state_next;
    logic [31:0]                    rem_reg, rem_next;
    logic [31:0]                    monto_reg, monto_next;
    logic [N_TIPOS-1:0][CNT_W-1:0]  cnt_reg, cnt_next;
    logic [N_TIPOS-1:0][CNT_W-1:0]  shadow_reg, shadow_next;
    logic                           req_reg, req_next;
    tipo_t                          tipo_reg, tipo_next;
    logic                           completa_reg, completa_next;
    logic                           invalido_reg, invalido_next;

    logic [N_TIPOS-1:0][31:0]       den;
    logic [N_TIPOS-1:0][CNT_W-1:0]  sel_cnt;
    logic                           sel_valido;
    tipo_t                          sel_tipo;
    logic [CNT_W:0]                 recarga_suma;
    logic [CNT_W-1:0]               recarga_sat;
    logic [31:0]                    rem_tras_ack;

`ifdef DISP_TIMEOUT_EN
    localparam int TMO_W = $clog2((TIMEOUT_CICLOS > 1) ? TIMEOUT_CICLOS : 2);
    logic [TMO_W-1:0] tmo_reg, tmo_next;
    logic             falla_reg, falla_next;
`endif

    assign den[0] = 32'(DEN0);
    assign den[1] = 32'(DEN1);
    assign den[2] = 32'(DEN2);
    assign den[3] = 32'(DEN3);

    // The dry run works on a private copy so a rejected amount leaves inventory intact.
    assign sel_cnt = (state_reg == VERIFICA) ? shadow_reg : cnt_reg;

    selector_billete #(
        .CNT_W (CNT_W)
    ) u_selector (
        .rem    (rem_reg),
        .cnt    (sel_cnt),
        .den    (den),
        .valido (sel_valido),
        .tipo   (sel_tipo)
    );

    assign recarga_suma = {1'b0, cnt_reg[RECARGA_TIPO]} + {1'b0, RECARGA_CANT};
    assign recarga_sat  = recarga_suma[CNT_W] ? '1 : recarga_suma[CNT_W-1:0];
    assign rem_tras_ack = rem_reg - den[tipo_reg];

    always_comb begin
        state_next    = state_reg;
        rem_next      = rem_reg;
        monto_next    = monto_reg;
        cnt_next      = cnt_reg;
        shadow_next   = shadow_reg;
        req_next      = req_reg;
        tipo_next     = tipo_reg;
        completa_next = 1'b0;
        invalido_next = 1'b0;
`ifdef DISP_TIMEOUT_EN
        tmo_next      = tmo_reg;
        falla_next    = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (ENTREGAR_DINERO) begin
                    rem_next    = MONTO;
                    monto_next  = MONTO;
                    shadow_next = cnt_reg;
                    state_next  = VERIFICA;
                end else if (RECARGA_STB) begin
                    cnt_next[RECARGA_TIPO] = recarga_sat;
                end
            end
            VERIFICA: begin
                if (sel_valido) begin
                    rem_next              = rem_reg - den[sel_tipo];
                    shadow_next[sel_tipo] = shadow_reg[sel_tipo] - UNO;
                end else if ((rem_reg == 32'd0) && (monto_reg != 32'd0)) begin
                    rem_next   = monto_reg;
                    state_next = ENTREGA;
                end else begin
                    invalido_next = 1'b1;
                    state_next    = IDLE;
                end
            end
            ENTREGA: begin
                if (sel_valido) begin
                    req_next   = 1'b1;
                    tipo_next  = sel_tipo;
                    state_next = ESPERA_ACK;
`ifdef DISP_TIMEOUT_EN
                    tmo_next   = '0;
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            ESPERA_ACK: begin
                if (BILLETE_ACK && req_reg) begin
                    req_next           = 1'b0;
                    cnt_next[tipo_reg] = cnt_reg[tipo_reg] - UNO;
                    rem_next           = rem_tras_ack;
                    if (rem_tras_ack == 32'd0) begin
                        completa_next = 1'b1;
                        state_next    = IDLE;
                    end else begin
                        state_next = ENTREGA;
                    end
                end
`ifdef DISP_TIMEOUT_EN
                else if (tmo_reg == TMO_W'(TIMEOUT_CICLOS - 1)) begin
                    req_next   = 1'b0;
                    falla_next = 1'b1;
                    state_next = IDLE;
                end else begin
                    tmo_next = tmo_reg + TMO_W'(1);
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            rem_reg      <= '0;
            monto_reg    <= '0;
            cnt_reg      <= '0;
            shadow_reg   <= '0;
            req_reg      <= 1'b0;
            tipo_reg     <= TIPO_0;
            completa_reg <= 1'b0;
            invalido_reg <= 1'b0;
`ifdef DISP_TIMEOUT_EN
            tmo_reg      <= '0;
            falla_reg    <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            rem_reg      <= rem_next;
            monto_reg    <= monto_next;
            cnt_reg      <= cnt_next;
            shadow_reg   <= shadow_next;
            req_reg      <= req_next;
            tipo_reg     <= tipo_next;
            completa_reg <= completa_next;
            invalido_reg <= invalido_next;
`ifdef DISP_TIMEOUT_EN
            tmo_reg      <= tmo_next;
            falla_reg    <= falla_next;
`endif
        end
    end

    assign BILLETE_REQ      = req_reg;
    assign BILLETE_TIPO     = tipo_reg;
    assign OCUPADO          = (state_reg != IDLE);
    assign ENTREGA_COMPLETA = completa_reg;
    assign MONTO_INVALIDO   = invalido_reg;
`ifdef DISP_TIMEOUT_EN
    assign FALLA_MECANISMO  = falla_reg;
`else
    assign FALLA_MECANISMO  = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < N_TIPOS; gi++) begin : g_inventario
            assign INVENTARIO[gi*CNT_W +: CNT_W] = cnt_reg[gi];
        end
    endgenerate

endmodule
